// File: rtl/conv_block_sequencer.sv
// Address sequencer for the 2D convolver line memories: load, process and block readout phases.
// Latency: state, counters, o_changeBlock and o_err are registered (one cycle after the causing edge); o_writeAdd/o_fsm_SOP/o_fsm_valid_conv/o_EoP decode registered state.
// Backpressure: none; the host paces LOAD/READ with i_valid rising edges, PROC free-runs one address per cycle.
//
// Ports:
//   i_CLK, i_reset          clock and synchronous active-high reset
//   i_imgLength             image column count (must be stable outside IDLE)
//   i_load, i_SoP, i_abort  host commands
//   i_valid                 data strobe; only its rising edge advances LOAD/READ
//   o_readAdd, o_writeAdd   line-memory addresses
//   o_fsm_SOP, o_fsm_valid_conv  processing phase / convolver valid
//   o_changeBlock, o_err    single-cycle pulses
//   o_EoP, o_block_count    readout pending / blocks read since the last PROC
//   o_state                 current state for debug
module conv_block_sequencer #(
    parameter int NB_ADDRESS = 10,
    parameter int NB_IMAGE   = 10,
    parameter int N_CONV     = 16,
    parameter int LATENCIA   = 6,
    parameter int KERNEL     = 3,
    parameter int NB_STATES  = 3
) (
    input  logic                          i_CLK,
    input  logic                          i_reset,
    input  logic [NB_IMAGE-1:0]           i_imgLength,
    input  logic                          i_load,
    input  logic                          i_SoP,
    input  logic                          i_valid,
    input  logic                          i_abort,
    output logic [NB_ADDRESS-1:0]         o_readAdd,
    output logic [NB_ADDRESS-1:0]         o_writeAdd,
    output logic                          o_fsm_SOP,
    output logic                          o_fsm_valid_conv,
    output logic                          o_changeBlock,
    output logic                          o_EoP,
    output logic [$clog2(N_CONV+1)-1:0]   o_block_count,
    output logic                          o_err,
    output logic [NB_STATES-1:0]          o_state
);

    localparam int NB_BLK = $clog2(N_CONV+1);
    localparam int TRIM   = KERNEL - 1;

    localparam logic [NB_ADDRESS-1:0] ONE_A   = NB_ADDRESS'(1);
    localparam logic [NB_ADDRESS-1:0] TRIM_A  = NB_ADDRESS'(TRIM);
    localparam logic [NB_ADDRESS-1:0] LAT_A   = NB_ADDRESS'(LATENCIA);
    // Shortest image that still yields at least one output after pipeline fill and trim.
    localparam logic [NB_ADDRESS-1:0] MIN_LEN = NB_ADDRESS'(LATENCIA + TRIM + 1);
    localparam logic [NB_BLK-1:0]     ONE_B   = NB_BLK'(1);
    localparam logic [NB_BLK-1:0]     NCONV_B = NB_BLK'(N_CONV);

    typedef enum logic [NB_STATES-1:0] {
        S_IDLE = NB_STATES'(0),
        S_LOAD = NB_STATES'(1),
        S_PROC = NB_STATES'(2),
        S_DONE = NB_STATES'(3),
        S_READ = NB_STATES'(4)
    } state_t;

    state_t              state_q, state_d;
    logic [NB_ADDRESS-1:0] rd_cnt_q, rd_cnt_d;
    logic [NB_ADDRESS-1:0] wr_cnt_q, wr_cnt_d;
    logic [NB_BLK-1:0]     readout_left_q, readout_left_d;
    logic [NB_BLK-1:0]     block_count_q, block_count_d;
    logic                  change_block_q, change_block_d;
    logic                  err_q, err_d;
    logic                  v_prev_q;

    logic [NB_ADDRESS-1:0] img_len;
    logic [NB_ADDRESS-1:0] wr_last;
    logic                  stb;

    assign img_len = NB_ADDRESS'(i_imgLength);
    // Last valid output column after the kernel edge trim; also the READ terminal count.
    assign wr_last = img_len - TRIM_A;
    assign stb     = i_valid & ~v_prev_q;

    always_comb begin
        state_d        = state_q;
        rd_cnt_d       = rd_cnt_q;
        wr_cnt_d       = wr_cnt_q;
        readout_left_d = readout_left_q;
        block_count_d  = block_count_q;
        change_block_d = 1'b0;
        err_d          = 1'b0;

        case (state_q)
            S_IDLE: begin
                rd_cnt_d = '0;
                wr_cnt_d = '0;
                if (i_load && !i_SoP && readout_left_q == '0) begin
                    state_d = S_LOAD;
                end else if (i_SoP && !i_load && readout_left_q == '0) begin
                    if (img_len < MIN_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        state_d       = S_PROC;
                        block_count_d = '0;
                    end
                end else if (!i_load && !i_SoP && readout_left_q != '0) begin
                    state_d        = S_READ;
                    readout_left_d = readout_left_q - ONE_B;
                end else if (i_load && i_SoP) begin
                    err_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (stb) begin
                    if (rd_cnt_q == img_len) begin
                        state_d        = S_IDLE;
                        rd_cnt_d       = '0;
                        change_block_d = 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + ONE_A;
                    end
                end
            end
            S_READ: begin
                if (stb) begin
                    if (rd_cnt_q == wr_last) begin
                        state_d        = S_IDLE;
                        rd_cnt_d       = '0;
                        change_block_d = 1'b1;
                        if (block_count_q != NCONV_B) begin
                            block_count_d = block_count_q + ONE_B;
                        end
                    end else begin
                        rd_cnt_d = rd_cnt_q + ONE_A;
                    end
                end
            end
            S_PROC: begin
                if (rd_cnt_q < img_len) begin
                    rd_cnt_d = rd_cnt_q + ONE_A;
                end
                // Writes start once the first read has travelled through the pipeline.
                if ((rd_cnt_q >= LAT_A) && (wr_cnt_q < wr_last)) begin
                    wr_cnt_d = wr_cnt_q + ONE_A;
                end
                if (wr_cnt_q == wr_last) begin
                    state_d        = S_DONE;
                    change_block_d = 1'b1;
                    readout_left_d = NCONV_B;
                end
            end
            S_DONE: begin
                if (!i_SoP) begin
                    state_d  = S_IDLE;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort keeps the block count so the host can see how far readout got.
        if (i_abort) begin
            state_d        = S_IDLE;
            rd_cnt_d       = '0;
            wr_cnt_d       = '0;
            readout_left_d = '0;
            block_count_d  = block_count_q;
            change_block_d = 1'b0;
            err_d          = 1'b0;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state_q        <= S_IDLE;
            rd_cnt_q       <= '0;
            wr_cnt_q       <= '0;
            readout_left_q <= '0;
            block_count_q  <= '0;
            change_block_q <= 1'b0;
            err_q          <= 1'b0;
            v_prev_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_cnt_q       <= rd_cnt_d;
            wr_cnt_q       <= wr_cnt_d;
            readout_left_q <= readout_left_d;
            block_count_q  <= block_count_d;
            change_block_q <= change_block_d;
            err_q          <= err_d;
            v_prev_q       <= i_valid;
        end
    end

    assign o_fsm_SOP        = (state_q == S_PROC);
    assign o_readAdd        = rd_cnt_q;
    assign o_writeAdd       = o_fsm_SOP ? wr_cnt_q : rd_cnt_q;
    assign o_fsm_valid_conv = o_fsm_SOP && (wr_cnt_q < (wr_last - ONE_A));
    assign o_changeBlock    = change_block_q;
    assign o_EoP            = (readout_left_q != '0);
    assign o_block_count    = block_count_q;
    assign o_err            = err_q;
    assign o_state          = state_q;

endmodule

// File: tb/tb_conv_block_sequencer.sv
module tb_conv_block_sequencer;

    logic       clk;
    logic       i_reset;
    logic [9:0] i_imgLength;
    logic       i_load, i_SoP, i_valid, i_abort;
    logic [9:0] o_readAdd, o_writeAdd;
    logic       o_fsm_SOP, o_fsm_valid_conv, o_changeBlock, o_EoP, o_err;
    logic [4:0] o_block_count;
    logic [2:0] o_state;

    int checks = 0;
    int errors = 0;

    conv_block_sequencer dut (
        .i_CLK           (clk),
        .i_reset         (i_reset),
        .i_imgLength     (i_imgLength),
        .i_load          (i_load),
        .i_SoP           (i_SoP),
        .i_valid         (i_valid),
        .i_abort         (i_abort),
        .o_readAdd       (o_readAdd),
        .o_writeAdd      (o_writeAdd),
        .o_fsm_SOP       (o_fsm_SOP),
        .o_fsm_valid_conv(o_fsm_valid_conv),
        .o_changeBlock   (o_changeBlock),
        .o_EoP           (o_EoP),
        .o_block_count   (o_block_count),
        .o_err           (o_err),
        .o_state         (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_imgLength = 10'd10;
        i_load = 1'b0; i_SoP = 1'b0; i_valid = 1'b0; i_abort = 1'b0;
        tick(); tick();
        checks++;
        if ({o_state, o_readAdd, o_writeAdd, o_fsm_SOP, o_fsm_valid_conv, o_changeBlock,
             o_EoP, o_block_count, o_err} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs state=%0d rd=%0d wr=%0d sop=%b vc=%b cb=%b eop=%b blk=%0d err=%b required all zero",
                     o_state, o_readAdd, o_writeAdd, o_fsm_SOP, o_fsm_valid_conv, o_changeBlock,
                     o_EoP, o_block_count, o_err);
        end
        i_reset = 1'b0;
        tick();
        checks++;
        if (o_state !== 3'd0) begin
            errors++; $display("FAIL reset_release state=%0d required 0", o_state);
        end
    endtask

    task automatic test_load();
        i_imgLength = 10'd10;
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        checks++;
        if (o_state !== 3'd1 || o_readAdd !== 10'd0) begin
            errors++; $display("FAIL load_enter state=%0d rd=%0d required 1/0", o_state, o_readAdd);
        end
        for (int k = 1; k <= 11; k++) begin
            i_valid = 1'b1;
            tick();
            checks++;
            if (k <= 10) begin
                if (o_state !== 3'd1 || o_readAdd !== 10'(k) || o_writeAdd !== 10'(k) || o_changeBlock !== 1'b0) begin
                    errors++;
                    $display("FAIL load_step%0d state=%0d rd=%0d wr=%0d cb=%b required 1/%0d/%0d/0",
                             k, o_state, o_readAdd, o_writeAdd, o_changeBlock, k, k);
                end
            end else begin
                if (o_state !== 3'd0 || o_changeBlock !== 1'b1 || o_readAdd !== 10'd0) begin
                    errors++;
                    $display("FAIL load_exit state=%0d cb=%b rd=%0d required 0/1/0", o_state, o_changeBlock, o_readAdd);
                end
            end
            i_valid = 1'b0;
            tick();
        end
        checks++;
        if (o_changeBlock !== 1'b0 || o_state !== 3'd0) begin
            errors++; $display("FAIL load_cb_width cb=%b state=%0d required 0/0", o_changeBlock, o_state);
        end
    endtask

    task automatic test_proc();
        int exp_rd, exp_wr;
        i_imgLength = 10'd10;
        i_SoP = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            tick();
            exp_rd = (c > 10) ? 10 : c;
            exp_wr = (c <= 6) ? 0 : ((c - 6 > 8) ? 8 : c - 6);
            checks++;
            if (o_state !== 3'd2 || o_fsm_SOP !== 1'b1 || o_readAdd !== 10'(exp_rd) ||
                o_writeAdd !== 10'(exp_wr) || o_fsm_valid_conv !== (exp_wr < 7)) begin
                errors++;
                $display("FAIL proc_c%0d state=%0d sop=%b rd=%0d wr=%0d vc=%b required 2/1/%0d/%0d/%b",
                         c, o_state, o_fsm_SOP, o_readAdd, o_writeAdd, o_fsm_valid_conv,
                         exp_rd, exp_wr, exp_wr < 7);
            end
        end
        tick();
        checks++;
        if (o_state !== 3'd3 || o_changeBlock !== 1'b1 || o_EoP !== 1'b1 || o_fsm_SOP !== 1'b0 ||
            o_fsm_valid_conv !== 1'b0) begin
            errors++;
            $display("FAIL proc_done state=%0d cb=%b eop=%b sop=%b vc=%b required 3/1/1/0/0",
                     o_state, o_changeBlock, o_EoP, o_fsm_SOP, o_fsm_valid_conv);
        end
        tick();
        checks++;
        if (o_state !== 3'd3 || o_changeBlock !== 1'b0) begin
            errors++; $display("FAIL done_hold state=%0d cb=%b required 3/0", o_state, o_changeBlock);
        end
        i_SoP = 1'b0;
        tick();
        checks++;
        if (o_state !== 3'd0 || o_EoP !== 1'b1 || o_readAdd !== 10'd0) begin
            errors++; $display("FAIL done_exit state=%0d eop=%b rd=%0d required 0/1/0", o_state, o_EoP, o_readAdd);
        end
    endtask

    task automatic test_readout();
        for (int p = 1; p <= 16; p++) begin
            for (int w = 0; w < 3 && o_state !== 3'd4; w++) tick();
            checks++;
            if (o_state !== 3'd4 || o_readAdd !== 10'd0 || o_EoP !== (p < 16)) begin
                errors++;
                $display("FAIL read_enter%0d state=%0d rd=%0d eop=%b required 4/0/%b", p, o_state, o_readAdd, o_EoP, p < 16);
            end
            // Terminal count is 10 - 2 = 8: eight advancing pulses, the ninth ends the pass.
            for (int k = 1; k <= 9; k++) begin
                i_valid = 1'b1;
                tick();
                i_valid = 1'b0;
                if (k < 9) begin
                    checks++;
                    if (o_state !== 3'd4 || o_readAdd !== 10'(k)) begin
                        errors++;
                        $display("FAIL read%0d_step%0d state=%0d rd=%0d required 4/%0d", p, k, o_state, o_readAdd, k);
                    end
                    tick();
                end else begin
                    checks++;
                    if (o_state !== 3'd0 || o_changeBlock !== 1'b1 || o_block_count !== 5'(p)) begin
                        errors++;
                        $display("FAIL read%0d_exit state=%0d cb=%b blk=%0d required 0/1/%0d", p, o_state, o_changeBlock, o_block_count, p);
                    end
                end
            end
        end
        tick();
        checks++;
        if (o_state !== 3'd0 || o_EoP !== 1'b0 || o_block_count !== 5'd16 || o_changeBlock !== 1'b0) begin
            errors++;
            $display("FAIL readout_end state=%0d eop=%b blk=%0d cb=%b required 0/0/16/0", o_state, o_EoP, o_block_count, o_changeBlock);
        end
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        checks++;
        if (o_state !== 3'd1) begin
            errors++; $display("FAIL load_after_readout state=%0d required 1", o_state);
        end
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        checks++;
        if (o_state !== 3'd0 || o_block_count !== 5'd16) begin
            errors++; $display("FAIL abort_keeps_blk state=%0d blk=%0d required 0/16", o_state, o_block_count);
        end
    endtask

    task automatic test_errors();
        i_imgLength = 10'd10;
        i_load = 1'b1; i_SoP = 1'b1;
        tick();
        i_load = 1'b0; i_SoP = 1'b0;
        checks++;
        if (o_err !== 1'b1 || o_state !== 3'd0) begin
            errors++; $display("FAIL err_load_sop err=%b state=%0d required 1/0", o_err, o_state);
        end
        tick();
        checks++;
        if (o_err !== 1'b0) begin
            errors++; $display("FAIL err_pulse_width err=%b required 0", o_err);
        end
        i_imgLength = 10'd8;
        i_SoP = 1'b1;
        tick();
        i_SoP = 1'b0;
        checks++;
        if (o_err !== 1'b1 || o_state !== 3'd0) begin
            errors++; $display("FAIL err_short_img err=%b state=%0d required 1/0", o_err, o_state);
        end
        tick();
        checks++;
        if (o_err !== 1'b0 || o_state !== 3'd0) begin
            errors++; $display("FAIL err_short_after err=%b state=%0d required 0/0", o_err, o_state);
        end
        // Length 9 is the smallest accepted image.
        i_imgLength = 10'd9;
        i_SoP = 1'b1;
        tick();
        checks++;
        if (o_err !== 1'b0 || o_state !== 3'd2 || o_block_count !== 5'd0) begin
            errors++; $display("FAIL min_len_accept err=%b state=%0d blk=%0d required 0/2/0", o_err, o_state, o_block_count);
        end
        i_SoP = 1'b0; i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        i_imgLength = 10'd10;
    endtask

    task automatic test_abort();
        i_imgLength = 10'd10;
        i_SoP = 1'b1;
        for (int c = 0; c <= 5; c++) tick();
        checks++;
        if (o_state !== 3'd2 || o_readAdd !== 10'd5) begin
            errors++; $display("FAIL abort_pre state=%0d rd=%0d required 2/5", o_state, o_readAdd);
        end
        i_SoP = 1'b0; i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        checks++;
        if (o_state !== 3'd0 || o_readAdd !== 10'd0 || o_writeAdd !== 10'd0 || o_EoP !== 1'b0 ||
            o_changeBlock !== 1'b0 || o_fsm_SOP !== 1'b0) begin
            errors++;
            $display("FAIL abort_proc state=%0d rd=%0d wr=%0d eop=%b cb=%b sop=%b required 0/0/0/0/0/0",
                     o_state, o_readAdd, o_writeAdd, o_EoP, o_changeBlock, o_fsm_SOP);
        end
        tick();
        checks++;
        if (o_changeBlock !== 1'b0 || o_state !== 3'd0) begin
            errors++; $display("FAIL abort_no_cb cb=%b state=%0d required 0/0", o_changeBlock, o_state);
        end
    endtask

    task automatic test_reset_mid();
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            i_valid = 1'b1; tick();
            i_valid = 1'b0; tick();
        end
        checks++;
        if (o_state !== 3'd1 || o_readAdd !== 10'd4) begin
            errors++; $display("FAIL mid_pre state=%0d rd=%0d required 1/4", o_state, o_readAdd);
        end
        // A rising i_valid at the reset edge must lose to reset.
        i_valid = 1'b1; i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        checks++;
        if ({o_state, o_readAdd, o_writeAdd, o_fsm_SOP, o_fsm_valid_conv, o_changeBlock,
             o_EoP, o_block_count, o_err} !== 37'd0) begin
            errors++;
            $display("FAIL mid_reset state=%0d rd=%0d wr=%0d cb=%b eop=%b blk=%0d err=%b required all zero",
                     o_state, o_readAdd, o_writeAdd, o_changeBlock, o_EoP, o_block_count, o_err);
        end
        tick();
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (o_state !== 3'd1 || o_readAdd !== 10'd0) begin
            errors++; $display("FAIL held_valid_no_stb state=%0d rd=%0d required 1/0", o_state, o_readAdd);
        end
        i_valid = 1'b0; tick();
        i_valid = 1'b1; tick();
        checks++;
        if (o_readAdd !== 10'd1) begin
            errors++; $display("FAIL toggled_valid_stb rd=%0d required 1", o_readAdd);
        end
        i_valid = 1'b0;
        i_abort = 1'b1; tick();
        i_abort = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_proc();
        test_readout();
        test_errors();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall guard so a stuck run still ends with a verdict.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout reached 200000ns required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
